// File: rtl/transform_state_sync.sv
// transform_state_sync: owns the live transform state and sequences the switch-input
// block (update tick, pose capture, bounded wait for the float-adder scale result).
// On frame_start it hands the renderer a frame-consistent snapshot over valid/ready.
// Optional build macro TRANSFORM_OVERRUN_CNT_EN adds overrun_cnt_out, a saturating
// count of frame_start pulses dropped while a snapshot was still waiting for ready.
module transform_state_sync #(
  parameter int unsigned TICK_PERIOD = 10_000_000,
  parameter int unsigned SCALE_WAIT  = 16,
  parameter logic [31:0] SCALE_RESET = 32'h3F80_0000
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            hold_in,
  input  logic            frame_start_in,
  input  logic [2:0][8:0] upd_translate_in,
  input  logic [4:0]      upd_pitch_in,
  input  logic [4:0]      upd_roll_in,
  input  logic [4:0]      upd_yaw_in,
  input  logic [31:0]     upd_scale_in,
  input  logic            upd_scale_valid_in,
  output logic            tick_out,
  output logic [2:0][8:0] cur_translate_out,
  output logic [31:0]     cur_scale_out,
  output logic [4:0]      cur_pitch_out,
  output logic [4:0]      cur_roll_out,
  output logic [4:0]      cur_yaw_out,
  output logic [2:0][8:0] snap_translate_out,
  output logic [31:0]     snap_scale_out,
  output logic [4:0]      snap_pitch_out,
  output logic [4:0]      snap_roll_out,
  output logic [4:0]      snap_yaw_out,
  output logic            snap_valid_out,
  input  logic            snap_ready_in
`ifdef TRANSFORM_OVERRUN_CNT_EN
  ,
  output logic [15:0]     overrun_cnt_out
`endif
);

  localparam int unsigned CNT_W  = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam int unsigned WAIT_W = $clog2(SCALE_WAIT + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(TICK_PERIOD - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(SCALE_WAIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TICK,
    ST_CAPTURE,
    ST_WAIT_SCALE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              tick_q, tick_d;

  logic [2:0][8:0]   cur_tr_q, cur_tr_d;
  logic [31:0]       cur_scale_q, cur_scale_d;
  logic [4:0]        cur_pitch_q, cur_pitch_d;
  logic [4:0]        cur_roll_q, cur_roll_d;
  logic [4:0]        cur_yaw_q, cur_yaw_d;

  logic [2:0][8:0]   snap_tr_q, snap_tr_d;
  logic [31:0]       snap_scale_q, snap_scale_d;
  logic [4:0]        snap_pitch_q, snap_pitch_d;
  logic [4:0]        snap_roll_q, snap_roll_d;
  logic [4:0]        snap_yaw_q, snap_yaw_d;
  logic              snap_valid_q, snap_valid_d;

  logic              tick_due;

  // Free-running tick counter; a tick is due when the count is about to reach its last value,
  // so tick_out is high exactly in the cycle the counter shows TICK_PERIOD-1.
  always_comb begin
    cnt_d    = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
    tick_due = (cnt_d == LAST_CNT) && !hold_in;
  end

  // Update sequencer: tick, capture pose, then wait a bounded time for the scale strobe.
  always_comb begin
    state_d     = state_q;
    tick_d      = 1'b0;
    wait_d      = wait_q;
    cur_tr_d    = cur_tr_q;
    cur_scale_d = cur_scale_q;
    cur_pitch_d = cur_pitch_q;
    cur_roll_d  = cur_roll_q;
    cur_yaw_d   = cur_yaw_q;
    case (state_q)
      ST_IDLE: begin
        if (tick_due) begin
          state_d = ST_TICK;
          tick_d  = 1'b1;
        end
      end
      ST_TICK: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        cur_tr_d    = upd_translate_in;
        cur_pitch_d = upd_pitch_in;
        cur_roll_d  = upd_roll_in;
        cur_yaw_d   = upd_yaw_in;
        wait_d      = '0;
        state_d     = ST_WAIT_SCALE;
      end
      ST_WAIT_SCALE: begin
        if (upd_scale_valid_in) begin
          cur_scale_d = upd_scale_in;
          state_d     = ST_IDLE;
        end else if (wait_q == LAST_WAIT) begin
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Snapshot handshake: load from pre-edge live state, back-to-back reload keeps valid high.
  always_comb begin
    snap_tr_d    = snap_tr_q;
    snap_scale_d = snap_scale_q;
    snap_pitch_d = snap_pitch_q;
    snap_roll_d  = snap_roll_q;
    snap_yaw_d   = snap_yaw_q;
    snap_valid_d = snap_valid_q;
    if (frame_start_in && (!snap_valid_q || snap_ready_in)) begin
      snap_tr_d    = cur_tr_q;
      snap_scale_d = cur_scale_q;
      snap_pitch_d = cur_pitch_q;
      snap_roll_d  = cur_roll_q;
      snap_yaw_d   = cur_yaw_q;
      snap_valid_d = 1'b1;
    end else if (snap_valid_q && snap_ready_in) begin
      snap_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous reset to the power-on pose.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      wait_q       <= '0;
      tick_q       <= 1'b0;
      cur_tr_q     <= '0;
      cur_scale_q  <= SCALE_RESET;
      cur_pitch_q  <= '0;
      cur_roll_q   <= '0;
      cur_yaw_q    <= '0;
      snap_tr_q    <= '0;
      snap_scale_q <= SCALE_RESET;
      snap_pitch_q <= '0;
      snap_roll_q  <= '0;
      snap_yaw_q   <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wait_q       <= wait_d;
      tick_q       <= tick_d;
      cur_tr_q     <= cur_tr_d;
      cur_scale_q  <= cur_scale_d;
      cur_pitch_q  <= cur_pitch_d;
      cur_roll_q   <= cur_roll_d;
      cur_yaw_q    <= cur_yaw_d;
      snap_tr_q    <= snap_tr_d;
      snap_scale_q <= snap_scale_d;
      snap_pitch_q <= snap_pitch_d;
      snap_roll_q  <= snap_roll_d;
      snap_yaw_q   <= snap_yaw_d;
      snap_valid_q <= snap_valid_d;
    end
  end

`ifdef TRANSFORM_OVERRUN_CNT_EN
  logic [15:0] ovr_q, ovr_d;

  // Saturating count of frame_start pulses dropped while the renderer stalls.
  always_comb begin
    ovr_d = ovr_q;
    if (frame_start_in && snap_valid_q && !snap_ready_in && (ovr_q != 16'hFFFF)) begin
      ovr_d = ovr_q + 16'd1;
    end
  end

  // Overrun counter register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ovr_q <= '0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign overrun_cnt_out = ovr_q;
`endif

  assign tick_out           = tick_q;
  assign cur_translate_out  = cur_tr_q;
  assign cur_scale_out      = cur_scale_q;
  assign cur_pitch_out      = cur_pitch_q;
  assign cur_roll_out       = cur_roll_q;
  assign cur_yaw_out        = cur_yaw_q;
  assign snap_translate_out = snap_tr_q;
  assign snap_scale_out     = snap_scale_q;
  assign snap_pitch_out     = snap_pitch_q;
  assign snap_roll_out      = snap_roll_q;
  assign snap_yaw_out       = snap_yaw_q;
  assign snap_valid_out     = snap_valid_q;

endmodule
